// File: rtl/seven_seg_mixed_radix_disp.sv
// Seven-segment driver: a sequential mixed-radix double-dabble engine feeds display
// registers, which drive registered active-low segments with blink, blanking and overflow dashes.
module seven_seg_mixed_radix_disp #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 19,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [8*NUM_DIGITS-1:0] segs
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VALUE_W + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(VALUE_W - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_bitCnt;
    logic [VALUE_W-1:0]    r_shift;
    logic                  r_workMode;
    logic [DW-1:0]         r_work;
    logic                  r_convOvf;
    logic                  r_pendValid;
    logic [VALUE_W-1:0]    r_pendValue;
    logic                  r_pendMode;
    logic [DW-1:0]         r_disp;
    logic                  r_dispMode;
    logic                  r_overflow;
    logic                  r_done;
    logic [8*NUM_DIGITS-1:0] r_segs;
    logic [BW-1:0]         r_blinkCnt;
    logic                  r_blinkOn;

    logic [DW-1:0]         w_workNext;
    logic                  w_carry;
    logic                  w_carryOut;
    logic [3:0]            w_dig;
    logic [3:0]            w_half;
    logic                  w_start;
    logic [VALUE_W-1:0]    w_startValue;
    logic                  w_startMode;
    logic [8*NUM_DIGITS-1:0] w_segsNext;
    logic                  w_lead;
    logic                  w_nz;
    logic [7:0]            w_glyph;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // One add-then-shift step; radix-6 digits get +5 so a shift past 5 carries out.
    always_comb begin
        w_carry    = r_shift[VALUE_W-1];
        w_workNext = '0;
        w_dig      = '0;
        w_half     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_dig  = r_work[4*i +: 4];
            w_half = (r_workMode && (i == 3 || i == 5)) ? 4'd3 : 4'd5;
            if (w_dig >= w_half) w_dig = w_dig + (4'd8 - w_half);
            w_workNext[4*i +: 4] = {w_dig[2:0], w_carry};
            w_carry = w_dig[3];
        end
        w_carryOut = w_carry;
    end

    // In the done cycle a newer load supersedes whatever was pending.
    always_comb begin
        w_start      = ((r_state == S_IDLE) && load) ||
                       ((r_state == S_DONE) && (load || r_pendValid));
        w_startValue = load ? value : r_pendValue;
        w_startMode  = load ? mode  : r_pendMode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_workMode  <= 1'b0;
            r_work      <= '0;
            r_convOvf   <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendValue <= '0;
            r_pendMode  <= 1'b0;
            r_disp      <= '0;
            r_dispMode  <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_CONV: begin
                    r_shift   <= r_shift << 1;
                    r_work    <= w_workNext;
                    r_convOvf <= r_convOvf | w_carryOut;
                    r_bitCnt  <= r_bitCnt + 1'b1;
                    if (load) begin
                        r_pendValid <= 1'b1;
                        r_pendValue <= value;
                        r_pendMode  <= mode;
                    end
                    if (r_bitCnt == LAST_BIT) begin
                        r_disp     <= w_workNext;
                        r_dispMode <= r_workMode;
                        r_overflow <= r_convOvf | w_carryOut;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_shift     <= w_startValue;
                        r_workMode  <= w_startMode;
                        r_work      <= '0;
                        r_convOvf   <= 1'b0;
                        r_bitCnt    <= '0;
                        r_pendValid <= 1'b0;
                        r_state     <= S_CONV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= ~r_blinkOn;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    // Walk from the top digit down; w_lead stays set while only zeros have been seen.
    always_comb begin
        w_segsNext = '1;
        w_lead     = 1'b1;
        w_nz       = 1'b0;
        w_glyph    = 8'hFF;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nz    = (r_disp[4*i +: 4] != 4'd0);
            w_glyph = glyph(r_disp[4*i +: 4]);
            if (r_dispMode && (i == 2 || i == 4)) w_glyph[7] = 1'b0;
            if (!enable || (blink_mask[i] && !r_blinkOn))
                w_segsNext[8*i +: 8] = 8'hFF;
            else if (r_overflow)
                w_segsNext[8*i +: 8] = 8'hBF;
            else if (!r_dispMode && w_lead && !w_nz && i != 0)
                w_segsNext[8*i +: 8] = 8'hFF;
            else
                w_segsNext[8*i +: 8] = w_glyph;
            w_lead = w_lead && !w_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_segs <= '1;
        else        r_segs <= w_segsNext;
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign segs     = r_segs;

endmodule

// File: tb/tb_seven_seg_mixed_radix_disp.sv
// Bench for seven_seg_mixed_radix_disp: an arithmetic reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_seven_seg_mixed_radix_disp;
    localparam int ND = 6;
    localparam int VW = 19;
    localparam int BD = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            mode;
    logic [VW-1:0]   value;
    logic            load;
    logic [ND-1:0]   blink_mask;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [8*ND-1:0] segs;

    int nVectors     = 0;
    int nMiscompares = 0;

    // Reference model state: conversion job timing, pending slot, displayed value.
    int              mEdge = 0;
    int              mStart = 0;
    bit              mActive = 0;
    int              mActVal = 0;
    bit              mActMode = 0;
    bit              mPendValid = 0;
    int              mPendVal = 0;
    bit              mPendMode = 0;
    int              mDispVal = 0;
    bit              mDispMode = 0;
    bit              mDispOvf = 0;
    logic            expBusy = 1'b0;
    logic            expDone = 1'b0;
    logic            expOvf  = 1'b0;
    logic [8*ND-1:0] expSegs = '1;

    seven_seg_mixed_radix_disp #(
        .NUM_DIGITS(ND),
        .VALUE_W   (VW),
        .BLINK_DIV (BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .value     (value),
        .load      (load),
        .blink_mask(blink_mask),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .segs      (segs)
    );

    always #5 clk = ~clk;

    function automatic int radixOf(input int i, input bit m);
        return (m && (i == 3 || i == 5)) ? 6 : 10;
    endfunction

    function automatic int capacity(input bit m);
        int c = 1;
        for (int i = 0; i < ND; i++) c = c * radixOf(i, m);
        return c;
    endfunction

    function automatic logic [7:0] glyphOf(input int d);
        logic [7:0] table10 [10];
        table10 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return table10[d];
    endfunction

    function automatic logic [8*ND-1:0] modelSegs(input int v, input bit m, input bit ovf,
                                                 input bit en, input logic [ND-1:0] mask,
                                                 input bit phaseOn);
        int d [ND];
        int rem = v;
        int top = 0;
        logic [8*ND-1:0] r;
        logic [7:0] s;
        for (int i = 0; i < ND; i++) begin
            d[i] = rem % radixOf(i, m);
            rem  = rem / radixOf(i, m);
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < ND; i++) begin
            if (!en || (mask[i] && !phaseOn)) s = 8'hFF;
            else if (ovf)                      s = 8'hBF;
            else if (!m && i > top)            s = 8'hFF;
            else begin
                s = glyphOf(d[i]);
                if (m && (i == 2 || i == 4)) s = s & 8'h7F;
            end
            r[8*i +: 8] = s;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic startJob(input int v, input bit m);
        mActive  = 1;
        mStart   = mEdge;
        mActVal  = v;
        mActMode = m;
        mPendValid = 0;
    endtask

    // Model: each job shows done 19 edges after its start edge; the edge after that
    // starts a coincident load or the pending job, otherwise the engine idles.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mEdge = 0; mActive = 0; mPendValid = 0;
            mDispVal = 0; mDispMode = 0; mDispOvf = 0;
            expBusy = 1'b0; expDone = 1'b0; expOvf = 1'b0; expSegs = '1;
        end else begin
            expSegs = modelSegs(mDispVal, mDispMode, mDispOvf, enable, blink_mask,
                                ((mEdge / BD) % 2) == 0);
            expDone = 1'b0;
            if (!mActive) begin
                if (load) startJob(int'(value), mode);
            end else if (mEdge - mStart == VW) begin
                mDispVal  = mActVal;
                mDispMode = mActMode;
                mDispOvf  = (mActVal >= capacity(mActMode));
                expDone   = 1'b1;
                if (load) begin mPendValid = 1; mPendVal = int'(value); mPendMode = mode; end
            end else if (mEdge - mStart == VW + 1) begin
                if (load)            startJob(int'(value), mode);
                else if (mPendValid) startJob(mPendVal, mPendMode);
                else                 mActive = 0;
            end else if (load) begin
                mPendValid = 1; mPendVal = int'(value); mPendMode = mode;
            end
            mEdge++;
            expBusy = mActive;
            expOvf  = mDispOvf;
        end
    end

    initial forever begin
        @(negedge clk);
        checkOutput("segs", 64'(segs), 64'(expSegs));
        checkOutput("busy", 64'(busy), 64'(expBusy));
        checkOutput("done", 64'(done), 64'(expDone));
        checkOutput("overflow", 64'(overflow), 64'(expOvf));
    end

    task automatic applyStimulus(input bit ld, input int v, input bit m);
        @(negedge clk);
        load  = ld;
        value = v[VW-1:0];
        mode  = m;
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        load = 1'b0;
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic loadAndWait(input int v, input bit m, output int lat);
        applyStimulus(1'b1, v, m);
        applyStimulus(1'b0, 0, 1'b0);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL doneTimeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    initial begin
        int lat;
        int gap;
        int r;
        int v;
        bit doneSeen;
        logic [7:0] s [12];

        rst_n = 1'b0; enable = 1'b1; mode = 1'b0; value = '0; load = 1'b0; blink_mask = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetSegs", 64'(segs), 64'({8*ND{1'b1}}));
        checkOutput("resetBusy", 64'(busy), 64'd0);
        #2 rst_n = 1'b1;

        checkOutput("modelPinTime", 64'(modelSegs(359999, 1, 0, 1, '0, 1)), 64'h92_10_92_10_90_90);
        checkOutput("modelPinDec", 64'(modelSegs(1234, 0, 0, 1, '0, 1)), 64'hFF_FF_F9_A4_B0_99);

        loadAndWait(1234, 1'b0, lat);
        checkOutput("t1Latency", 64'(lat), 64'd20);
        checkOutput("t1Ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        checkOutput("t1Segs", 64'(segs), 64'hFF_FF_F9_A4_B0_99);

        loadAndWait(359999, 1'b1, lat);
        @(negedge clk);
        checkOutput("t2Segs", 64'(segs), 64'h92_10_92_10_90_90);

        loadAndWait(360000, 1'b1, lat);
        checkOutput("t3Ovf", 64'(overflow), 64'd1);
        @(negedge clk);
        checkOutput("t3Segs", 64'(segs), 64'hBF_BF_BF_BF_BF_BF);
        loadAndWait(0, 1'b0, lat);
        checkOutput("t3OvfClear", 64'(overflow), 64'd0);
        @(negedge clk);
        checkOutput("t3Zero", 64'(segs), 64'hFF_FF_FF_FF_FF_C0);

        applyStimulus(1'b1, 42, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 77, 1'b0);
        applyStimulus(1'b1, 88, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        lat = 5;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        checkOutput("t4Latency1", 64'(lat), 64'd20);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) checkOutput("t4Segs42", 64'(segs), 64'hFF_FF_FF_FF_99_A4);
        end while (!done && gap < 100);
        checkOutput("t4Gap", 64'(gap), 64'd20);
        @(negedge clk);
        checkOutput("t4Segs88", 64'(segs), 64'hFF_FF_FF_FF_80_80);

        loadAndWait(5, 1'b0, lat);
        blink_mask = 6'b000001;
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            s[j] = segs[7:0];
            checkOutput("t5Glyph", 64'((s[j] == 8'h92) || (s[j] == 8'hFF)), 64'd1);
            checkOutput("t5Others", 64'(segs[8*ND-1:8]), 64'hFF_FF_FF_FF_FF);
            if (j >= 4) checkOutput("t5Toggle", 64'(s[j] != s[j-4]), 64'd1);
        end
        blink_mask = '0;

        applyStimulus(1'b1, 55555, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6SegsReset", 64'(segs), 64'({8*ND{1'b1}}));
        checkOutput("t6BusyReset", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        doneSeen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) doneSeen = 1'b1;
        end
        checkOutput("t6NoDone", 64'(doneSeen), 64'd0);
        loadAndWait(987, 1'b0, lat);
        checkOutput("t6Latency", 64'(lat), 64'd20);
        @(negedge clk);
        checkOutput("t6Segs", 64'(segs), 64'hFF_FF_FF_90_80_F8);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(399) == 0) begin
                applyReset(2);
            end else begin
                r = int'($urandom_range(3));
                case (r)
                    0:       v = int'($urandom_range(99));
                    1:       v = int'($urandom_range(359999));
                    2:       v = 359990 + int'($urandom_range(19));
                    default: v = int'($urandom_range((1 << VW) - 1));
                endcase
                applyStimulus($urandom_range(5) == 0, v, 1'($urandom_range(1)));
                enable     = ($urandom_range(15) != 0);
                blink_mask = ($urandom_range(3) == 0) ? ND'($urandom) : '0;
            end
        end
        applyStimulus(1'b0, 0, 1'b0);
        repeat (45) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
